win_scanner: RTL and testbench

- Downstream consumer of the 5x5 board register block. Takes the 25 two-bit cell codes after each placement and decides whether player 1 or player 2 has five in a row, or whether the board is drawn.
- Scans the 12 winning lines (5 rows, 5 columns, 2 diagonals) sequentially from a snapshot of the board. Reports the winner and the winning line index to the game-control and display logic.

---
 rtl/win_scanner.sv | 152 +++++++++++++++
 tb/tb_win_scanner.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/win_scanner.sv
// Sequential 5x5 five-in-a-row scanner: evaluates LINES_PER_CYCLE lines per clock from a board snapshot.
// Optional full-board draw reporting is enabled with `define WIN_SCANNER_DRAW_DETECT_EN.
module win_scanner #(
  parameter int LINES_PER_CYCLE = 1,
  parameter int SIDE            = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        start,
  input  logic [49:0] board_flat,
  output logic        busy,
  output logic        result_valid,
  output logic [1:0]  winner,
  output logic [3:0]  win_line,
  output logic        game_over
);

  // state | meaning
  // IDLE  | no scan since reset/clr
  // SCAN  | evaluating one line group per clock against the snapshot
  // DONE  | result presented, held until next accepted start or clr
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int         NLINES     = 12;
  localparam logic [3:0] LAST_GROUP = 4'(NLINES / LINES_PER_CYCLE - 1);

  generate
    if (!(LINES_PER_CYCLE == 1 || LINES_PER_CYCLE == 2 || LINES_PER_CYCLE == 3 ||
          LINES_PER_CYCLE == 4 || LINES_PER_CYCLE == 6 || LINES_PER_CYCLE == 12)) begin : g_bad_lpc
      $error("win_scanner: LINES_PER_CYCLE must be 1, 2, 3, 4, 6 or 12");
    end
    if (SIDE != 5) begin : g_bad_side
      $error("win_scanner: only SIDE = 5 is supported");
    end
  endgenerate

  logic [1:0]  state;
  logic [3:0]  grp;
  logic [49:0] snap;

  logic        hit;
  logic [3:0]  hit_line;
  logic [1:0]  hit_code;

  // zero-based cell index of the j-th cell of a line
  function automatic int cell_idx(input int line, input int j);
    if (line < 5)        return 5 * line + j;
    else if (line < 10)  return (line - 5) + 5 * j;
    else if (line == 10) return 6 * j;
    else                 return 4 + 4 * j;
  endfunction

  // descending loop so the lowest-index winner in the current group is kept
  always_comb begin
    logic       p1;
    logic       p2;
    logic [1:0] code;
    hit      = 1'b0;
    hit_line = 4'd0;
    hit_code = 2'b00;
    p1       = 1'b0;
    p2       = 1'b0;
    code     = 2'b00;
    for (int l = NLINES - 1; l >= 0; l--) begin
      p1 = 1'b1;
      p2 = 1'b1;
      for (int j = 0; j < 5; j++) begin
        code = snap[2*cell_idx(l, j) +: 2];
        p1   = p1 & (code == 2'b01);
        p2   = p2 & (code == 2'b10);
      end
      if ((l / LINES_PER_CYCLE) == int'(grp) && (p1 || p2)) begin
        hit      = 1'b1;
        hit_line = 4'(l);
        hit_code = p1 ? 2'b01 : 2'b10;
      end
    end
  end

`ifdef WIN_SCANNER_DRAW_DETECT_EN
  logic full;
  always_comb begin
    full = 1'b1;
    for (int k = 0; k < 25; k++) begin
      if (snap[2*k +: 2] == 2'b00) full = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      grp          <= 4'd0;
      snap         <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      winner       <= 2'b00;
      win_line     <= 4'd0;
      game_over    <= 1'b0;
    end else if (clr) begin
      state        <= IDLE;
      grp          <= 4'd0;
      snap         <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      winner       <= 2'b00;
      win_line     <= 4'd0;
      game_over    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start && !game_over) begin
            state        <= SCAN;
            snap         <= board_flat;
            grp          <= 4'd0;
            busy         <= 1'b1;
            result_valid <= 1'b0;
            winner       <= 2'b00;
            win_line     <= 4'd0;
          end
        end
        SCAN: begin
          if (hit) begin
            state        <= DONE;
            winner       <= hit_code;
            win_line     <= hit_line;
            busy         <= 1'b0;
            result_valid <= 1'b1;
            game_over    <= 1'b1;
          end else if (grp == LAST_GROUP) begin
            state        <= DONE;
            busy         <= 1'b0;
            result_valid <= 1'b1;
`ifdef WIN_SCANNER_DRAW_DETECT_EN
            if (full) begin
              winner    <= 2'b11;
              game_over <= 1'b1;
            end
`endif
          end else begin
            grp <= grp + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_win_scanner.sv
// Bench for win_scanner: L=1 and L=4 instances share stimulus; directed table, corner sequences, random boards vs. a line-list model.
module tb_win_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic [49:0] board_flat = '0;

  logic [1:0] busy_v, rv_v, go_v;
  logic [1:0] win_v  [2];
  logic [3:0] line_v [2];

  int LV [2] = '{1, 4};

`ifdef WIN_SCANNER_DRAW_DETECT_EN
  localparam bit DRAW_EN = 1'b1;
`else
  localparam bit DRAW_EN = 1'b0;
`endif

  win_scanner #(.LINES_PER_CYCLE(1), .SIDE(5)) dut1 (
    .clk(clk), .rst(rst), .clr(clr), .start(start), .board_flat(board_flat),
    .busy(busy_v[0]), .result_valid(rv_v[0]), .winner(win_v[0]),
    .win_line(line_v[0]), .game_over(go_v[0])
  );

  win_scanner #(.LINES_PER_CYCLE(4), .SIDE(5)) dut4 (
    .clk(clk), .rst(rst), .clr(clr), .start(start), .board_flat(board_flat),
    .busy(busy_v[1]), .result_valid(rv_v[1]), .winner(win_v[1]),
    .win_line(line_v[1]), .game_over(go_v[1])
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int lines [12][5];

  typedef struct {
    logic [49:0] board;
    logic [1:0]  w;
    logic [3:0]  ln;
  } vec_t;
  vec_t vt [8];

  task automatic check(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic logic [49:0] put(input logic [49:0] b, input int k, input logic [1:0] c);
    b[2*k-2 +: 2] = c;
    return b;
  endfunction

  function automatic logic [49:0] line_board(input logic [49:0] b, input int ln, input logic [1:0] c);
    for (int j = 0; j < 5; j++) b = put(b, lines[ln][j], c);
    return b;
  endfunction

  function automatic logic [49:0] full_nowin();
    logic [49:0] b;
    logic [1:0]  c;
    b = '0;
    for (int r = 0; r < 5; r++)
      for (int col = 0; col < 5; col++) begin
        c = (col == 2 || col == 3) ? 2'b10 : 2'b01;
        if (r % 2 == 1) c = ~c;
        b = put(b, 5*r + col + 1, c);
      end
    return b;
  endfunction

  // reference: first line in list order whose five cells all hold 01 or all hold 10
  task automatic model(input logic [49:0] b, output logic [1:0] w, output logic [3:0] ln);
    logic [1:0] c0;
    bit         same;
    bit         full;
    w = 2'b00;
    ln = 4'd0;
    for (int i = 0; i < 12; i++) begin
      c0 = b[2*lines[i][0]-2 +: 2];
      same = (c0 == 2'b01 || c0 == 2'b10);
      for (int j = 1; j < 5; j++) if (b[2*lines[i][j]-2 +: 2] != c0) same = 0;
      if (same) begin
        w = c0;
        ln = 4'(i);
        return;
      end
    end
    full = 1;
    for (int k = 1; k <= 25; k++) if (b[2*k-2 +: 2] == 2'b00) full = 0;
    if (full && DRAW_EN) w = 2'b11;
  endtask

  function automatic int exp_lat(input int l, input logic [1:0] w, input logic [3:0] ln);
    if (w == 2'b01 || w == 2'b10) return 1 + int'(ln) / l;
    return 12 / l;
  endfunction

  task automatic pulse_clr();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic run_scan(input logic [49:0] b, input logic [1:0] ew, input logic [3:0] el,
                          input string nm, input bit disturb, input logic [49:0] alt);
    int lat [2];
    bit early;
    @(negedge clk); board_flat = b; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int d = 0; d < 2; d++) check($sformatf("%s_busy_start_L%0d", nm, LV[d]), busy_v[d], 1);
    lat = '{-1, -1};
    early = 0;
    for (int k = 1; k <= 20 && (lat[0] < 0 || lat[1] < 0); k++) begin
      if (disturb && k == 1) begin
        @(negedge clk); board_flat = alt; start = 1'b1;
      end
      @(posedge clk); #1; start = 1'b0;
      for (int d = 0; d < 2; d++)
        if (lat[d] < 0) begin
          if (rv_v[d]) lat[d] = k;
          else if (!busy_v[d]) early = 1;
        end
    end
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_lat_L%0d", nm, LV[d]), lat[d], exp_lat(LV[d], ew, el));
      check($sformatf("%s_winner_L%0d", nm, LV[d]), win_v[d], ew);
      check($sformatf("%s_line_L%0d", nm, LV[d]), line_v[d], el);
      check($sformatf("%s_gameover_L%0d", nm, LV[d]), go_v[d], (ew != 2'b00) ? 1 : 0);
      check($sformatf("%s_busy_done_L%0d", nm, LV[d]), busy_v[d], 0);
    end
    check($sformatf("%s_busy_early", nm), early, 0);
    pulse_clr();
  endtask

  task automatic check_zero(input string nm);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_busy_L%0d", nm, LV[d]), busy_v[d], 0);
      check($sformatf("%s_rv_L%0d", nm, LV[d]), rv_v[d], 0);
      check($sformatf("%s_winner_L%0d", nm, LV[d]), win_v[d], 0);
      check($sformatf("%s_line_L%0d", nm, LV[d]), line_v[d], 0);
      check($sformatf("%s_go_L%0d", nm, LV[d]), go_v[d], 0);
    end
  endtask

  initial begin
    logic [49:0] b, partial;
    logic [1:0]  mw;
    logic [3:0]  ml;

    for (int r = 0; r < 5; r++)
      for (int j = 0; j < 5; j++) begin
        lines[r][j]     = 5*r + j + 1;
        lines[5 + r][j] = r + 1 + 5*j;
      end
    for (int j = 0; j < 5; j++) begin
      lines[10][j] = 1 + 6*j;
      lines[11][j] = 5 + 4*j;
    end

    partial = '0;
    for (int k = 1; k <= 4; k++) partial = put(partial, k, 2'b01);
    for (int k = 6; k <= 9; k++) partial = put(partial, k, 2'b10);

    vt[0] = '{line_board('0, 1, 2'b01), 2'b01, 4'd1};
    vt[1] = '{line_board('0, 11, 2'b10), 2'b10, 4'd11};
    vt[2] = '{partial, 2'b00, 4'd0};
    vt[3] = '{line_board('0, 7, 2'b10), 2'b10, 4'd7};
    vt[4] = '{line_board('0, 10, 2'b01), 2'b01, 4'd10};
    vt[5] = '{line_board(line_board('0, 4, 2'b01), 0, 2'b10), 2'b10, 4'd0};
    vt[6] = '{line_board('0, 2, 2'b11), 2'b00, 4'd0};
    vt[7] = '{full_nowin(), DRAW_EN ? 2'b11 : 2'b00, 4'd0};

    #12;
    check_zero("reset");
    @(negedge clk); rst = 1'b1;

    for (int i = 0; i < 8; i++)
      run_scan(vt[i].board, vt[i].w, vt[i].ln, $sformatf("vec%0d", i), 0, '0);

    // new board and a second start mid-scan must not disturb the first scan
    run_scan(partial, 2'b00, 4'd0, "snapshot", 1, line_board('0, 0, 2'b01));

    // clr at edge N+3 aborts
    @(negedge clk); board_flat = partial; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); clr = 1'b1;
    @(posedge clk); #1; clr = 1'b0;
    check_zero("clr_abort");

    // win, then a start while game_over must be ignored
    @(negedge clk); board_flat = line_board('0, 1, 2'b01); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    board_flat = line_board('0, 11, 2'b10); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (15) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("hold_winner_L%0d", LV[d]), win_v[d], 1);
      check($sformatf("hold_line_L%0d", LV[d]), line_v[d], 1);
      check($sformatf("hold_rv_L%0d", LV[d]), rv_v[d], 1);
      check($sformatf("hold_busy_L%0d", LV[d]), busy_v[d], 0);
    end
    pulse_clr();

    // asynchronous reset mid-scan
    @(negedge clk); board_flat = partial; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    check_zero("async_rst");
    @(negedge clk); rst = 1'b1;
    run_scan(line_board('0, 11, 2'b10), 2'b10, 4'd11, "after_rst", 0, '0);

    for (int n = 0; n < 40; n++) begin
      b = '0;
      for (int k = 1; k <= 25; k++) b = put(b, k, 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1)
        b = line_board(b, int'($urandom_range(0, 11)), 2'($urandom_range(1, 2)));
      model(b, mw, ml);
      run_scan(b, mw, ml, $sformatf("rand%0d", n), 0, '0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
